// File: rtl/uart_tx_param_if.sv
// Source-side handshake into the parametrised UART transmitter: a word on
// tx_data is accepted on the clock edge where tx_valid and tx_ready are both high.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first data, optional parity, 1 or 2 stop bits,
// BAUD_DIV clocks per bit, and a one-word holding register for gapless back-to-back frames.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 1
) (
    input  logic            clk_baud,
    input  logic            rst,
    uart_tx_param_if.slave  bus,
    output logic            tx,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 1) begin : g_bad_baud_div
        $error("uart_tx_param: BAUD_DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept;
    logic bit_end;
    logic last_stop;
    logic load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        accept    = bus.tx_valid && !hold_full_q;
        bit_end   = (baud_cnt_q == '0);
        last_stop = (state_q == S_STOP) && bit_end && (bit_cnt_q == STOP_LAST);
        load      = hold_full_q && ((state_q == S_IDLE) || last_stop);

        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        if (state_q != S_IDLE && !bit_end) begin
            baud_cnt_d = baud_cnt_q - 1'b1;
        end

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d    = S_DATA;
                    bit_cnt_d  = '0;
                    baud_cnt_d = BAUD_LAST;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d    = shift_q >> 1;
                    baud_cnt_d = BAUD_LAST;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    bit_cnt_d  = '0;
                    baud_cnt_d = BAUD_LAST;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        baud_cnt_d = BAUD_LAST;
                    end
                end
            end
            default: ;
        endcase

        // Loading overrides the STOP->IDLE step so the next start bit follows with no gap.
        if (load) begin
            shift_d     = hold_q;
            parity_d    = (PARITY == 2) ? ~^hold_q : ^hold_q;
            state_d     = S_START;
            bit_cnt_d   = '0;
            baud_cnt_d  = BAUD_LAST;
            hold_full_d = accept;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (bit_cnt_d == STOP_LAST) && (baud_cnt_d == '0);
    end

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_ready = !hold_full_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule
